// File: rtl/digest_seq_pkg.sv
// rtl/digest_seq_pkg.sv - shared types, defaults and index helper for the digest display sequencer
// Purpose: state encoding, default dwell length and modular index stepping used by
//          digest_display_sequencer.
// Ports:   none (package).
package digest_seq_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    AUTO   = 2'd1,
    MANUAL = 2'd2,
    PAUSED = 2'd3
  } state_t;

  localparam int DEFAULT_DWELL_TICKS = 500;

  // Step an index one position modulo n. dir=0 steps forward, dir=1 steps back.
  function automatic int unsigned idx_step(input int unsigned idx, input logic dir,
                                           input int unsigned n);
    int unsigned r;
    if (dir) r = (idx == 0) ? n - 1 : idx - 1;
    else     r = (idx == n - 1) ? 0 : idx + 1;
    return r;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - two-flop button synchroniser with rising-edge pulse
// Purpose: brings a raw asynchronous button into the clock domain and emits a single-cycle
//          pulse per press; a held button produces exactly one pulse.
// Ports:   clk        in  clock
//          rst_n      in  asynchronous active-low reset
//          btn_in     in  raw button level
//          rise_pulse out one-cycle pulse, valid two clocks after btn_in is first sampled high
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic rise_pulse
);

  // [0] metastability stage, [1] synchronised level, [2] previous synchronised level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rise_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/digest_display_sequencer.sv
// rtl/digest_display_sequencer.sv - sequences a captured digest one word at a time to a display
// Purpose: captures a hash digest and presents it WORD_W bits per frame, with timed auto-scroll,
//          manual next/prev stepping and pause. Optional macro DIGEST_SEQ_BLANK_EN inserts one
//          blanked dwell period (idx held at 0) after every auto wrap; otherwise blank is tied 0.
// Ports:   sysclk_125mhz in  system clock
//          rst           in  asynchronous active-low reset
//          tick          in  one-cycle dwell strobe
//          digest_valid  in  one-cycle capture strobe for digest
//          digest        in  digest value [DIGEST_W]
//          mode_auto     in  1 = auto scroll, 0 = manual
//          btn_next/btn_prev/btn_pause in raw asynchronous buttons
//          word          out displayed word digest_reg[word_idx*WORD_W +: WORD_W]
//          word_idx      out current word index
//          have_digest   out a digest has been captured since reset
//          paused        out sequencer is paused
//          wrap_pulse    out one-cycle pulse when auto advance wraps N-1 -> 0
//          blank         out display blank request
module digest_display_sequencer
  import digest_seq_pkg::*;
#(
  parameter int DIGEST_W    = 512,
  parameter int WORD_W      = 16,
  parameter int DWELL_TICKS = DEFAULT_DWELL_TICKS,
  localparam int unsigned N = DIGEST_W / WORD_W,
  localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                sysclk_125mhz,
  input  logic                rst,
  input  logic                tick,
  input  logic                digest_valid,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                mode_auto,
  input  logic                btn_next,
  input  logic                btn_prev,
  input  logic                btn_pause,
  output logic [WORD_W-1:0]   word,
  output logic [IDX_W-1:0]    word_idx,
  output logic                have_digest,
  output logic                paused,
  output logic                wrap_pulse,
  output logic                blank
);

`ifdef DIGEST_SEQ_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  localparam int CNT_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_TICKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                state_q, state_d;
  logic [DIGEST_W-1:0]   digest_q, digest_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wrap_q, wrap_d;
  logic                  blank_q, blank_d;

  logic next_pulse, prev_pulse, pause_pulse;
  logic step_ev;

  btn_edge_sync u_sync_next (
    .clk        (sysclk_125mhz),
    .rst_n      (rst),
    .btn_in     (btn_next),
    .rise_pulse (next_pulse)
  );

  btn_edge_sync u_sync_prev (
    .clk        (sysclk_125mhz),
    .rst_n      (rst),
    .btn_in     (btn_prev),
    .rise_pulse (prev_pulse)
  );

  btn_edge_sync u_sync_pause (
    .clk        (sysclk_125mhz),
    .rst_n      (rst),
    .btn_in     (btn_pause),
    .rise_pulse (pause_pulse)
  );

  // next and prev in the same cycle cancel; prev_pulse then selects the direction
  assign step_ev = next_pulse ^ prev_pulse;

  always_comb begin
    state_d  = state_q;
    digest_d = digest_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    blank_d  = blank_q;

    if (digest_valid) begin
      digest_d = digest;
      idx_d    = '0;
      cnt_d    = '0;
      blank_d  = 1'b0;
      if (state_q == EMPTY) state_d = mode_auto ? AUTO : MANUAL;
    end else begin
      case (state_q)
        AUTO: begin
          if (!mode_auto) begin
            state_d = MANUAL;
            blank_d = 1'b0;
          end else if (pause_pulse) begin
            state_d = PAUSED;
            blank_d = 1'b0;
          end else if (step_ev) begin
            idx_d   = IDX_W'(idx_step(32'(idx_q), prev_pulse, N));
            cnt_d   = '0;
            blank_d = 1'b0;
          end else if (tick) begin
            if (cnt_q == LAST_CNT) begin
              cnt_d = '0;
              if (blank_q) begin
                // end of the blanked period: idx stays 0, normal scrolling resumes
                blank_d = 1'b0;
              end else begin
                idx_d = IDX_W'(idx_step(32'(idx_q), 1'b0, N));
                if (idx_q == LAST_IDX) begin
                  wrap_d  = 1'b1;
                  blank_d = BLANK_EN;
                end
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        MANUAL: begin
          if (mode_auto) begin
            state_d = AUTO;
            cnt_d   = '0;
          end else if (step_ev) begin
            idx_d = IDX_W'(idx_step(32'(idx_q), prev_pulse, N));
          end
        end
        PAUSED: begin
          if (!mode_auto) begin
            state_d = MANUAL;
          end else if (pause_pulse) begin
            state_d = AUTO;
            cnt_d   = '0;
          end else if (step_ev) begin
            idx_d = IDX_W'(idx_step(32'(idx_q), prev_pulse, N));
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge sysclk_125mhz or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      digest_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digest_q <= digest_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      blank_q  <= blank_d;
    end
  end

  assign word        = digest_q[idx_q*WORD_W +: WORD_W];
  assign word_idx    = idx_q;
  assign have_digest = (state_q != EMPTY);
  assign paused      = (state_q == PAUSED);
  assign wrap_pulse  = wrap_q;
  assign blank       = blank_q;

endmodule

// File: tb/tb_digest_display_sequencer.sv
// tb/tb_digest_display_sequencer.sv - self-checking bench for digest_display_sequencer
module tb_digest_display_sequencer;

  localparam int DW = 512;
  localparam int WW = 16;
  localparam int NW = DW / WW;
  localparam int DWELL = 4;
`ifdef DIGEST_SEQ_BLANK_EN
  localparam bit M_BLANK_EN = 1'b1;
`else
  localparam bit M_BLANK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          digest_valid = 1'b0;
  logic [DW-1:0] digest = '0;
  logic          mode_auto = 1'b0;
  logic          btn_next = 1'b0;
  logic          btn_prev = 1'b0;
  logic          btn_pause = 1'b0;
  logic [WW-1:0] word;
  logic [4:0]    word_idx;
  logic          have_digest, paused, wrap_pulse, blank;

  always #4 clk = ~clk;

  digest_display_sequencer #(
    .DIGEST_W    (DW),
    .WORD_W      (WW),
    .DWELL_TICKS (DWELL)
  ) dut (
    .sysclk_125mhz (clk),
    .rst           (rst),
    .tick          (tick),
    .digest_valid  (digest_valid),
    .digest        (digest),
    .mode_auto     (mode_auto),
    .btn_next      (btn_next),
    .btn_prev      (btn_prev),
    .btn_pause     (btn_pause),
    .word          (word),
    .word_idx      (word_idx),
    .have_digest   (have_digest),
    .paused        (paused),
    .wrap_pulse    (wrap_pulse),
    .blank         (blank)
  );

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=empty 1=auto 2=manual 3=paused, idx/cnt as plain integers,
  // button edges derived from the raw input history (action two samples after first high sample).
  int            m_mode, m_idx, m_cnt;
  bit            m_wrap, m_blank;
  logic [DW-1:0] m_dig;
  bit            hn[4], hp[4], hz[4];

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_cnt = 0; m_wrap = 0; m_blank = 0; m_dig = '0;
    for (int i = 0; i < 4; i++) begin hn[i] = 0; hp[i] = 0; hz[i] = 0; end
  endtask

  task automatic model_step();
    bit en, ep, ez;
    int step;
    for (int i = 3; i > 0; i--) begin hn[i] = hn[i-1]; hp[i] = hp[i-1]; hz[i] = hz[i-1]; end
    hn[0] = btn_next; hp[0] = btn_prev; hz[0] = btn_pause;
    en = hn[2] && !hn[3];
    ep = hp[2] && !hp[3];
    ez = hz[2] && !hz[3];
    step = int'(en) - int'(ep);
    m_wrap = 0;
    if (digest_valid) begin
      m_dig = digest; m_idx = 0; m_cnt = 0; m_blank = 0;
      if (m_mode == 0) m_mode = mode_auto ? 1 : 2;
    end else if (m_mode == 1) begin
      if (!mode_auto) begin m_mode = 2; m_blank = 0; end
      else if (ez) begin m_mode = 3; m_blank = 0; end
      else if (step != 0) begin m_idx = (m_idx + step + NW) % NW; m_cnt = 0; m_blank = 0; end
      else if (tick) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DWELL) begin
          m_cnt = 0;
          if (m_blank) m_blank = 0;
          else begin
            m_idx = (m_idx + 1) % NW;
            if (m_idx == 0) begin m_wrap = 1; m_blank = M_BLANK_EN; end
          end
        end
      end
    end else if (m_mode == 2) begin
      if (mode_auto) begin m_mode = 1; m_cnt = 0; end
      else if (step != 0) m_idx = (m_idx + step + NW) % NW;
    end else if (m_mode == 3) begin
      if (!mode_auto) m_mode = 2;
      else if (ez) begin m_mode = 1; m_cnt = 0; end
      else if (step != 0) m_idx = (m_idx + step + NW) % NW;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // which: 0=next 1=prev 2=pause 3=next+prev together
  task automatic press(input int which);
    btn_next  = (which == 0 || which == 3);
    btn_prev  = (which == 1 || which == 3);
    btn_pause = (which == 2);
    cycn(3);
    btn_next = 0; btn_prev = 0; btn_pause = 0;
    cycn(3);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("word", word, m_dig[m_idx*WW +: WW]);
      chk("word_idx", word_idx, m_idx);
      chk("have_digest", have_digest, m_mode != 0);
      chk("paused", paused, m_mode == 3);
      chk("wrap_pulse", wrap_pulse, m_wrap);
      chk("blank", blank, m_blank);
    end
  end

  logic [DW-1:0] d1, d2, dr;
  int wraps;

  initial begin
    for (int k = 0; k < NW; k++) begin
      d1[k*WW +: WW] = 16'h0100 + WW'(k);
      d2[k*WW +: WW] = 16'hA000 + WW'(k);
    end
    model_reset();
    @(negedge clk);
    cycn(3);
    rst = 1;
    checking = 1;

    // no digest yet: buttons and tick do nothing
    for (int i = 0; i < 20; i++) begin
      tick = 1'($urandom); mode_auto = 1'($urandom);
      btn_next = 1'($urandom); btn_prev = 1'($urandom); btn_pause = 1'($urandom);
      cyc();
    end
    btn_next = 0; btn_prev = 0; btn_pause = 0;
    cycn(4);
    chk("empty_idx", word_idx, 0);
    chk("empty_word", word, 0);
    chk("empty_have", have_digest, 0);

    // auto scroll from capture
    tick = 1; mode_auto = 1; digest = d1; digest_valid = 1;
    cyc();
    digest_valid = 0;
    cycn(4);
    chk("auto_idx1", word_idx, 1);
    chk("auto_word1", word, 16'h0101);
    wraps = 0;
    for (int i = 0; i < 124; i++) begin
      cyc();
      if (wrap_pulse) wraps++;
    end
    chk("wrap_idx0", word_idx, 0);
    chk("wrap_count", wraps, 1);
`ifdef DIGEST_SEQ_BLANK_EN
    chk("blank_on", blank, 1);
    cycn(3);
    chk("blank_held", blank, 1);
    chk("blank_idx", word_idx, 0);
    cyc();
    chk("blank_off", blank, 0);
    chk("blank_idx_after", word_idx, 0);
    cycn(4);
    chk("blank_resume_idx1", word_idx, 1);
`else
    chk("noblank", blank, 0);
`endif

    // manual stepping
    tick = 0; mode_auto = 0;
    cyc();
    digest = d1; digest_valid = 1;
    cyc();
    digest_valid = 0;
    for (int i = 0; i < 3; i++) press(0);
    for (int i = 0; i < 5; i++) press(1);
    chk("manual_idx30", word_idx, 30);
    chk("manual_word", word, 16'h011E);
    chk("model_idx30", m_idx, 30);
    press(3);
    chk("both_idx", word_idx, 30);

    // pause
    digest_valid = 1;
    cyc();
    digest_valid = 0;
    for (int i = 0; i < 5; i++) press(0);
    mode_auto = 1;
    cyc();
    press(2);
    chk("paused_on", paused, 1);
    tick = 1;
    cycn(20);
    chk("paused_idx", word_idx, 5);
    chk("paused_still", paused, 1);
    tick = 0;
    press(2);
    chk("resumed", paused, 0);
    tick = 1;
    cycn(3);
    chk("resume_idx5", word_idx, 5);
    cyc();
    chk("resume_idx6", word_idx, 6);

    // recapture mid-scroll, then async reset
    cycn(44);
    chk("auto_idx17", word_idx, 17);
    digest = d2; digest_valid = 1;
    cyc();
    digest_valid = 0;
    chk("recap_idx", word_idx, 0);
    chk("recap_word", word, 16'hA000);
    chk("model_recap_word", m_dig[15:0], 16'hA000);
    cycn(6);
    #2 rst = 0;
    #1;
    chk("rst_word", word, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_have", have_digest, 0);
    chk("rst_flags", {paused, wrap_pulse, blank}, 0);
    model_reset();
    cycn(2);
    rst = 1;
    cyc();

    // randomized operation against the model
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(1, 0) == 1);
      digest_valid = ($urandom_range(199, 0) == 0);
      if (digest_valid) begin
        for (int w = 0; w < DW / 32; w++) dr[w*32 +: 32] = $urandom;
        digest = dr;
      end
      if ($urandom_range(149, 0) == 0) mode_auto = ~mode_auto;
      if ($urandom_range(7, 0) == 0) btn_next = ~btn_next;
      if ($urandom_range(7, 0) == 0) btn_prev = ~btn_prev;
      if ($urandom_range(9, 0) == 0) btn_pause = ~btn_pause;
      cyc();
    end

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
